// File: rtl/accum_op_feeder.sv
// Command FIFO and operand sequencer feeding an add/subtract accumulator.
// Optional overflow stall: define ACCUM_FEEDER_OVF_STALL_EN.
module accum_op_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int REP_W  = 4
) (
  input  logic              i_clk,
  input  logic              ni_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [REP_W-1:0]  i_rep,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  input  logic              i_ovf,
  input  logic              i_resume,
  output logic              o_add_sub,
  output logic [DATA_W-1:0] o_a,
  output logic              o_acc_en,
  output logic              o_acc_clr,
  output logic              o_busy,
  output logic              o_ovf_halt,
  output logic [15:0]       o_beat_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 2 + REP_W + DATA_W;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [REP_W-1:0] REP_ONE = 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CLR} state_t;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              empty, full, push, pop, advance, halt_eff, freeze;
  logic [EW-1:0]     head;
  logic [1:0]        head_op;
  logic [REP_W-1:0]  head_rep;
  logic [DATA_W-1:0] head_data;

  state_t            state_q;
  logic [REP_W-1:0]  rem_q;
  logic [DATA_W-1:0] a_q;
  logic              sub_q, acc_en_q, clr_q;
  logic [15:0]       cnt_q;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_ready = !full && !i_flush;
  assign push    = i_valid && o_ready;

  assign head      = mem_q[rd_q[AW-1:0]];
  assign head_op   = head[EW-1 -: 2];
  assign head_rep  = head[DATA_W +: REP_W];
  assign head_data = head[DATA_W-1:0];

  // A new command may be taken when idle, after a clear, or on the final beat.
  assign advance = (state_q == S_IDLE) || (state_q == S_CLR) ||
                   ((state_q == S_ISSUE) && (rem_q == '0));
  assign pop     = advance && !empty && !halt_eff && !i_flush;
  assign freeze  = halt_eff && (state_q != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {i_op, i_rep, i_data};
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (i_flush) begin
      rd_q <= wr_q;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // rem_q counts beats still to issue after the one currently on o_acc_en.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      a_q      <= '0;
      sub_q    <= 1'b0;
      acc_en_q <= 1'b0;
      clr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (acc_en_q) cnt_q <= cnt_q + 16'd1;
      if (i_flush) begin
        state_q  <= S_IDLE;
        acc_en_q <= 1'b0;
        clr_q    <= 1'b0;
      end else if (freeze) begin
        acc_en_q <= 1'b0;
        clr_q    <= 1'b0;
      end else if (pop) begin
        case (head_op)
          OP_ADD, OP_SUB: begin
            state_q  <= S_ISSUE;
            a_q      <= head_data;
            sub_q    <= head_op[0];
            rem_q    <= (head_rep == '0) ? '0 : head_rep - REP_ONE;
            acc_en_q <= 1'b1;
            clr_q    <= 1'b0;
          end
          OP_CLR: begin
            state_q  <= S_CLR;
            acc_en_q <= 1'b0;
            clr_q    <= 1'b1;
          end
          default: begin
            state_q  <= S_IDLE;
            acc_en_q <= 1'b0;
            clr_q    <= 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          S_ISSUE: begin
            if (rem_q != '0) begin
              rem_q    <= rem_q - REP_ONE;
              acc_en_q <= 1'b1;
            end else begin
              state_q  <= S_IDLE;
              acc_en_q <= 1'b0;
            end
          end
          S_CLR: begin
            state_q <= S_IDLE;
            clr_q   <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            acc_en_q <= 1'b0;
            clr_q    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ACCUM_FEEDER_OVF_STALL_EN
  logic halt_q, acc_en_d1_q;

  // Overflow reported by the accumulator one cycle after the offending beat.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      halt_q      <= 1'b0;
      acc_en_d1_q <= 1'b0;
    end else begin
      acc_en_d1_q <= acc_en_q;
      if (i_flush || i_resume)      halt_q <= 1'b0;
      else if (i_ovf && acc_en_d1_q) halt_q <= 1'b1;
    end
  end

  assign halt_eff   = halt_q && !i_resume;
  assign o_ovf_halt = halt_q;
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = i_ovf ^ i_resume;
  assign halt_eff   = 1'b0;
  assign o_ovf_halt = 1'b0;
`endif

  assign o_add_sub  = sub_q;
  assign o_a        = a_q;
  assign o_acc_en   = acc_en_q;
  assign o_acc_clr  = clr_q;
  assign o_beat_cnt = cnt_q;
  assign o_busy     = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_accum_op_feeder.sv
// Scoreboard bench for accum_op_feeder: accepted commands expand into expected
// beat/clear events; a negedge monitor pops and compares each DUT event.
module tb_accum_op_feeder;
  localparam int DW = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0, i_flush = 1'b0, i_ovf = 1'b0, i_resume = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic [RW-1:0] i_rep = '0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready, o_add_sub, o_acc_en, o_acc_clr, o_busy, o_ovf_halt;
  logic [DW-1:0] o_a;
  logic [15:0]   o_beat_cnt;

  accum_op_feeder #(.DATA_W(DW), .DEPTH(4), .REP_W(RW)) dut (
    .i_clk(clk), .ni_rst(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rep(i_rep), .i_data(i_data), .i_flush(i_flush),
    .i_ovf(i_ovf), .i_resume(i_resume), .o_add_sub(o_add_sub), .o_a(o_a),
    .o_acc_en(o_acc_en), .o_acc_clr(o_acc_clr), .o_busy(o_busy),
    .o_ovf_halt(o_ovf_halt), .o_beat_cnt(o_beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic clr; logic [DW-1:0] a; logic sub;} ev_t;
  ev_t exp_q[$];
  ev_t mon_got, mon_exp;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int obs_beats = 0, first_evt_cyc = -1, last_evt_cyc = -1, last_gap = 0;
  int model_beats = 0;
  int last_acc_cyc = 0;
  int waited;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accumulate or clear cycle must match the next expected event.
  initial forever begin
    @(negedge clk);
    if (rst_n && (o_acc_en || o_acc_clr)) begin
      mon_got.clr = o_acc_clr;
      mon_got.a   = o_acc_clr ? '0 : o_a;
      mon_got.sub = o_acc_clr ? 1'b0 : o_add_sub;
      if (o_acc_en && o_acc_clr) check("en_and_clr_together", 1, 0);
      if (last_evt_cyc >= 0) last_gap = cyc - last_evt_cyc;
      last_evt_cyc = cyc;
      if (first_evt_cyc < 0) first_evt_cyc = cyc;
      if (o_acc_en) obs_beats++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got clr=%0b a=%0d sub=%0b expected none",
                 mon_got.clr, mon_got.a, mon_got.sub);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL event: got clr=%0b a=%0d sub=%0b expected clr=%0b a=%0d sub=%0b",
                   mon_got.clr, mon_got.a, mon_got.sub, mon_exp.clr, mon_exp.a, mon_exp.sub);
        end
      end
    end
  end

  task automatic model_accept(input logic [1:0] op, input logic [RW-1:0] rep, input logic [DW-1:0] d);
    int n;
    ev_t e;
    n = (rep == 0) ? 1 : int'(rep);
    case (op)
      2'b00, 2'b01: begin
        e.clr = 1'b0; e.a = d; e.sub = op[0];
        for (int k = 0; k < n; k++) exp_q.push_back(e);
        model_beats += n;
      end
      2'b10: begin
        e.clr = 1'b1; e.a = '0; e.sub = 1'b0;
        exp_q.push_back(e);
      end
      default: ;
    endcase
  endtask

  // Drivers start and end at posedge+1.
  task automatic push(input logic [1:0] op, input logic [RW-1:0] rep, input logic [DW-1:0] d,
                      output int w);
    w = 0;
    i_valid = 1'b1; i_op = op; i_rep = rep; i_data = d;
    forever begin
      @(negedge clk);
      if (o_ready) begin
        model_accept(op, rep, d);
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      w++;
      if (w > 300) begin
        check("push_timeout", w, 0);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (obs_beats >= n) break;
    end
    check("wait_beats_reached", (obs_beats >= n) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!o_busy && exp_q.size() == 0) break;
    end
    check({name, "_drain_in_time"}, (k < 500) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    check({name, "_beat_cnt"}, o_beat_cnt, model_beats & 16'hFFFF);
    check({name, "_busy"}, o_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic new_test();
    obs_beats = 0; first_evt_cyc = -1; last_evt_cyc = -1; last_gap = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_acc_en", o_acc_en, 0);
    check("rst_acc_clr", o_acc_clr, 0);
    check("rst_a", o_a, 0);
    check("rst_add_sub", o_add_sub, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf_halt", o_ovf_halt, 0);
    check("rst_beat_cnt", o_beat_cnt, 0);
    check("rst_ready", o_ready, 1);
    rst_n = 1'b1;
    idle(1);

    // Two single-beat ADDs back-to-back
    new_test();
    push(2'b00, 4'd1, 8'd5, waited);
    check("t1_latency_ref", 0, 0 * last_acc_cyc);
    begin
      int acc0;
      acc0 = last_acc_cyc;
      push(2'b00, 4'd1, 8'd10, waited);
      drain("t1");
      check("t1_first_beat_latency", first_evt_cyc, acc0 + 2);
    end
    check("t1_beats", obs_beats, 2);
    check("t1_gap", last_gap, 1);
    check("t1_a_hold", o_a, 10);
    check("t1_add_sub", o_add_sub, 0);

    // SUB repeated three times
    new_test();
    push(2'b01, 4'd3, 8'd30, waited);
    drain("t2");
    check("t2_beats", obs_beats, 3);
    check("t2_gap", last_gap, 1);
    check("t2_a_hold", o_a, 30);
    check("t2_add_sub", o_add_sub, 1);

    // CLEAR then ADD rep=0 with no bubble
    new_test();
    push(2'b10, 4'd0, 8'd0, waited);
    push(2'b00, 4'd0, 8'd70, waited);
    drain("t3");
    check("t3_beats", obs_beats, 1);
    check("t3_no_bubble", last_gap, 1);
    check("t3_a", o_a, 70);

    // Fill the FIFO behind a long command
    new_test();
    push(2'b00, 4'd15, 8'd1, waited);
    for (int k = 0; k < 4; k++) push(2'b00, 4'd1, 8'(k + 100), waited);
    @(negedge clk);
    check("t4_ready_low_full", o_ready, 0);
    @(posedge clk); #1;
    push(2'b01, 4'd2, 8'd200, waited);
    check("t4_fifth_waited_for_pop", (waited >= 8) ? 1 : 0, 1);
    drain("t4");
    check("t4_beats", obs_beats, 15 + 4 + 2);

    // Flush mid-command with entries queued and a concurrent push
    new_test();
    push(2'b00, 4'd10, 8'd9, waited);
    push(2'b00, 4'd2, 8'd11, waited);
    push(2'b01, 4'd2, 8'd12, waited);
    wait_beats(4);
    i_flush = 1'b1; i_valid = 1'b1; i_op = 2'b00; i_rep = 4'd1; i_data = 8'd99;
    @(negedge clk);
    check("t5_ready_low_on_flush", o_ready, 0);
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    foreach (exp_q[k]) if (!exp_q[k].clr) model_beats--;
    exp_q.delete();
    @(negedge clk);
    check("t5_acc_en_after_flush", o_acc_en, 0);
    check("t5_busy_after_flush", o_busy, 0);
    check("t5_a_kept", o_a, 9);
    @(posedge clk); #1;
    idle(5);
    drain("t5");

    // Overflow pulse after the second beat
    new_test();
    push(2'b00, 4'd4, 8'd70, waited);
    wait_beats(2);
    i_ovf = 1'b1;
    idle(1);
    i_ovf = 1'b0;
    @(negedge clk);
`ifdef ACCUM_FEEDER_OVF_STALL_EN
    check("t6_ovf_halt_set", o_ovf_halt, 1);
    @(posedge clk); #1;
    idle(3);
    check("t6_busy_while_halted", o_busy, 1);
    check("t6_beats_before_resume", obs_beats, 4);
    i_resume = 1'b1;
    idle(1);
    i_resume = 1'b0;
`else
    check("t6_ovf_halt_tied", o_ovf_halt, 0);
    @(posedge clk); #1;
`endif
    drain("t6");
    check("t6_beats", obs_beats, 4);
    check("t6_ovf_halt_clear", o_ovf_halt, 0);

    // Randomized command stream
    new_test();
    for (int k = 0; k < 40; k++) begin
      logic [1:0]    rop;
      logic [RW-1:0] rrep;
      logic [DW-1:0] rdat;
      rop  = 2'($urandom_range(0, 3));
      rrep = RW'($urandom_range(0, 7));
      rdat = DW'($urandom);
      push(rop, rrep, rdat, waited);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    drain("t7");

    // Asynchronous reset mid-ISSUE
    new_test();
    push(2'b01, 4'd10, 8'h55, waited);
    wait_beats(3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t8_acc_en", o_acc_en, 0);
    check("t8_acc_clr", o_acc_clr, 0);
    check("t8_a", o_a, 0);
    check("t8_add_sub", o_add_sub, 0);
    check("t8_busy", o_busy, 0);
    check("t8_ovf_halt", o_ovf_halt, 0);
    check("t8_beat_cnt", o_beat_cnt, 0);
    exp_q.delete();
    model_beats = 0;
    @(posedge clk); #1;
    idle(1);
    rst_n = 1'b1;
    idle(4);
    drain("t8");
    check("t8_no_beats_after_reset", o_acc_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
